regread: RTL
============

Name: regread

Overview:
- Register-read stage directly downstream of the issue queue.
- Accepts up to iwd issued micro-ops per cycle and holds the physical register file.
- Reads source operands, with same-cycle bypass from execute writeback, and registers the result into per-lane output slots consumed by the function units.
- Returns per-lane issue back-pressure to the issue queue and flushes on commit redirect.

Parameters:
- iwd, 4, issue/read lanes.
- ewd, 4, writeback ports (exe_bundle width).
- cwd, 4, commit width (com_bundle width).
- prsz, 128, physical registers; index width $clog2(prsz), taken from the low bits of 16-bit register fields.
- xlen, 64, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- iss_bundle  in  iwd x iss_bundle_t  issued ops; opid[15] = valid; prsa[1:0] sources; prsb[1:0] post-wakeup busy bits; prda destination.
- issue  out  iwd  lane i may accept this cycle.
- exe_bundle  in  ewd x exe_bundle_t  writeback; opid[15] = valid; prda; res (xlen).
- com_bundle  in  cwd x com_bundle_t  only com_bundle[0].redir is used.
- fu_accept  in  iwd  FU consumed rrd_bundle[i] this edge.
- rrd_bundle  out  iwd x rrd_bundle_t  iss_bundle fields plus rs1, rs2 (xlen); opid[15] = valid.

Behaviour:
- Reset (rst=0, async):
  - All output slot valid bits clear, so rrd_bundle = 0.
  - issue = 0 while rst is low.
  - PRF entries cleared to 0.
- Physical register 0:
  - Reads always return 0.
  - Writebacks with prda==0 are ignored.
- PRF write:
  - Each valid exe_bundle[j] writes res to prda at the edge.
  - Duplicate prda in one cycle: the highest j wins. Duplicates are illegal upstream; the bench flags them with an assertion.
- Lane handshake:
  - issue[i] = ~slot_valid[i] | fu_accept[i], forced 0 when redir=1.
  - Lanes are independent; no cross-lane ordering is enforced.
- Capture, one-cycle latency:
  - When issue[i] and iss_bundle[i].opid[15], slot i loads the bundle at the edge and rrd_bundle[i] is valid the next cycle.
  - When issue[i] and the bundle is invalid, slot i clears.
  - Otherwise slot i holds its contents unchanged.
- Operand value for source k (rs1 = k0, rs2 = k1), priority order:
  1. prsa[k]==0 -> 0.
  2. Match against a valid exe_bundle[j].prda this cycle -> res; highest j wins.
  3. Otherwise the PRF read value.
- Operand value rules:
  - Bypass is always applied regardless of prsb.
  - Captured operands are frozen while the slot stalls; no later wakeup modifies them.
- prsb[k]=1 with no matching writeback in the capture cycle is a protocol error: capture the PRF value and fire a bench assertion.
- Redirect (com_bundle[0].redir=1):
  - All slot valid bits clear at the edge, including slots being accepted that cycle.
  - issue = 0 that cycle.
  - The PRF is not flushed and writebacks that cycle still commit to it.
- Simultaneous fu_accept[i] and capture on lane i: the new op replaces the old; this is a full-throughput pipeline with no bubble.
- Unused outputs: rrd_bundle[i] = 0 when slot i is invalid.
- No combinational path from iss_bundle to rrd_bundle.
- issue depends only on slot_valid, fu_accept and redir.

Decomposition:
- New in types package: rrd_bundle_t, a superset of iss_bundle_t adding rs1 and rs2 [xlen-1:0].
- exe_bundle_t carries res; add it there if absent.
- PRF uses the existing mwpram: depth prsz, rports 2*iwd, wports ewd, width xlen.
  - Write-ordering (highest port wins) is provided by mwpram.
  - Bypass priority lives in regread.
- The bypass mux is a natural sub-module: rr_bypass (one source operand; inputs prsa, PRF value, exe_bundle; output value). Instantiate it 2*iwd times.

Test Plan:
- Basic read:
  - Write p5=0xA via exe_bundle[0], idle one cycle.
  - Issue lane0 with prsa={5,0}, fu_accept=1.
  - Next cycle rrd_bundle[0] is valid with rs1=0xA, rs2=0.
- Same-cycle bypass:
  - exe_bundle[2] writes p9=0x55 in the same cycle lane1 issues with prsa={9,9}, prsb={1,1}.
  - Next cycle rs1=rs2=0x55.
  - A later read of p9 also returns 0x55.
- Stall/hold:
  - Lane0 captured, fu_accept[0]=0 for 3 cycles: issue[0]=0 and rrd_bundle[0] is stable.
  - Meanwhile a write p5=0xB arrives; rs1 stays 0xA.
  - Raise fu_accept[0]: issue[0]=1 in the same cycle.
- Back-to-back throughput: 4 lanes valid every cycle with fu_accept=all-1s for 10 cycles -> 40 ops out, one per lane per cycle, zero bubbles, order preserved per lane.
- Redirect:
  - With slots 0-3 valid and new ops arriving, assert redir for 1 cycle: issue=0 that cycle and all rrd valid bits are 0 next cycle.
  - Writeback of p7=0x3 in the redir cycle is still readable afterwards.
- Reset mid-operation:
  - Drop rst asynchronously between edges with slots valid: rrd_bundle=0 and issue=0 immediately.
  - After release, a read of p5 returns 0 and writes to p0 read back 0.

Source files
------------

// File: rtl/regread_pkg.sv
// Shared widths and bundle types for the register-read stage and its neighbours.
package regread_pkg;
    localparam int IWD  = 4;
    localparam int EWD  = 4;
    localparam int CWD  = 4;
    localparam int PRSZ = 128;
    localparam int XLEN = 64;
    localparam int PRW  = $clog2(PRSZ);

    typedef struct packed {
        logic [15:0]      opid;
        logic [1:0][15:0] prsa;
        logic [1:0]       prsb;
        logic [15:0]      prda;
    } iss_bundle_t;

    typedef struct packed {
        logic [15:0]      opid;
        logic [15:0]      prda;
        logic [XLEN-1:0]  res;
    } exe_bundle_t;

    typedef struct packed {
        logic [15:0]      opid;
        logic             redir;
    } com_bundle_t;

    typedef struct packed {
        logic [15:0]      opid;
        logic [1:0][15:0] prsa;
        logic [1:0]       prsb;
        logic [15:0]      prda;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
    } rrd_bundle_t;

    function automatic logic op_vld(input logic [15:0] opid);
        return opid[15];
    endfunction
endpackage

// File: rtl/regread_if.sv
// Issue/writeback/commit inputs and FU-facing outputs of the register-read stage.
interface regread_if import regread_pkg::*; ();
    iss_bundle_t [IWD-1:0] iss_bundle;
    logic        [IWD-1:0] issue;
    exe_bundle_t [EWD-1:0] exe_bundle;
    com_bundle_t [CWD-1:0] com_bundle;
    logic        [IWD-1:0] fu_accept;
    rrd_bundle_t [IWD-1:0] rrd_bundle;

    modport master (
        output iss_bundle, exe_bundle, com_bundle, fu_accept,
        input  issue, rrd_bundle
    );

    modport slave (
        input  iss_bundle, exe_bundle, com_bundle, fu_accept,
        output issue, rrd_bundle
    );
endinterface

// File: rtl/mwpram.sv
// Multi-port register array: combinational reads, same-edge writes, highest write port wins.
// Contents clear on asynchronous active-low reset.
module mwpram #(
    parameter  int DEPTH  = 128,
    parameter  int RPORTS = 8,
    parameter  int WPORTS = 4,
    parameter  int WIDTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RPORTS-1:0][AW-1:0]     raddr,
    output logic [RPORTS-1:0][WIDTH-1:0]  rdata,
    input  logic [WPORTS-1:0]             we,
    input  logic [WPORTS-1:0][AW-1:0]     waddr,
    input  logic [WPORTS-1:0][WIDTH-1:0]  wdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            // later non-blocking writes override earlier ones: highest port wins
            for (int w = 0; w < WPORTS; w++) begin
                if (we[w]) mem_q[waddr[w]] <= wdata[w];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RPORTS; r++) rdata[r] = mem_q[raddr[r]];
    end
endmodule

// File: rtl/rr_bypass.sv
// One source operand: p0 reads zero, else youngest-port writeback match, else the PRF value.
// Purely combinational, no backpressure.
module rr_bypass import regread_pkg::*; (
    input  logic        [PRW-1:0]  prsa_i,
    input  logic        [XLEN-1:0] prf_i,
    input  exe_bundle_t [EWD-1:0]  exe_i,
    output logic        [XLEN-1:0] val_o
);
    logic exe_unused;

    always_comb begin
        val_o      = prf_i;
        exe_unused = 1'b0;
        for (int j = 0; j < EWD; j++) begin
            exe_unused = exe_unused ^ (^{exe_i[j].opid[14:0], exe_i[j].prda[15:PRW]});
            if (op_vld(exe_i[j].opid) && exe_i[j].prda[PRW-1:0] == prsa_i) val_o = exe_i[j].res;
        end
        if (prsa_i == '0) val_o = '0;
    end
endmodule

// File: rtl/regread.sv
// Register-read stage: PRF + bypass, one-cycle registered output slot per lane.
// Lane accepts when its slot is empty or being consumed; redirect flushes slots and blocks issue.
module regread import regread_pkg::*; (
    input  logic     clk,
    input  logic     rst,
    regread_if.slave bus
);
    logic                       redir;
    logic [IWD-1:0]             issue;
    rrd_bundle_t [IWD-1:0]      slot_q;
    rrd_bundle_t [IWD-1:0]      slot_d;
    logic [2*IWD-1:0][PRW-1:0]  rd_addr;
    logic [2*IWD-1:0][XLEN-1:0] rd_data;
    logic [2*IWD-1:0][XLEN-1:0] opnd;
    logic [EWD-1:0]             wr_en;
    logic [EWD-1:0][PRW-1:0]    wr_addr;
    logic [EWD-1:0][XLEN-1:0]   wr_data;
    logic                       com_unused;

    assign redir      = bus.com_bundle[0].redir;
    assign com_unused = ^{bus.com_bundle[CWD-1:1], bus.com_bundle[0].opid};

    // p0 is hardwired zero, so its writebacks never reach the array
    always_comb begin
        for (int j = 0; j < EWD; j++) begin
            wr_addr[j] = bus.exe_bundle[j].prda[PRW-1:0];
            wr_data[j] = bus.exe_bundle[j].res;
            wr_en[j]   = op_vld(bus.exe_bundle[j].opid) && (wr_addr[j] != '0);
        end
    end

    mwpram #(
        .DEPTH  (PRSZ),
        .RPORTS (2*IWD),
        .WPORTS (EWD),
        .WIDTH  (XLEN)
    ) u_prf (
        .clk   (clk),
        .rst   (rst),
        .raddr (rd_addr),
        .rdata (rd_data),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data)
    );

    for (genvar k = 0; k < 2*IWD; k++) begin : g_src
        assign rd_addr[k] = bus.iss_bundle[k/2].prsa[k%2][PRW-1:0];
        rr_bypass u_byp (
            .prsa_i (rd_addr[k]),
            .prf_i  (rd_data[k]),
            .exe_i  (bus.exe_bundle),
            .val_o  (opnd[k])
        );
    end

    always_comb begin
        for (int i = 0; i < IWD; i++) begin
            issue[i] = rst & ~redir & (~op_vld(slot_q[i].opid) | bus.fu_accept[i]);
        end
    end

    // invalid slots are kept all-zero so the output needs no masking
    always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < IWD; i++) begin
            if (redir) begin
                slot_d[i] = '0;
            end else if (issue[i]) begin
                slot_d[i] = '0;
                if (op_vld(bus.iss_bundle[i].opid)) begin
                    slot_d[i].opid = bus.iss_bundle[i].opid;
                    slot_d[i].prsa = bus.iss_bundle[i].prsa;
                    slot_d[i].prsb = bus.iss_bundle[i].prsb;
                    slot_d[i].prda = bus.iss_bundle[i].prda;
                    slot_d[i].rs1  = opnd[2*i];
                    slot_d[i].rs2  = opnd[2*i+1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) slot_q <= '0;
        else      slot_q <= slot_d;
    end

    assign bus.issue      = issue;
    assign bus.rrd_bundle = slot_q;
endmodule
